// File: rtl/regfile_dump_unit_pkg.sv
// regfile_dump_unit_pkg: state encoding and register count shared by the debug blocks
package regfile_dump_unit_pkg;
  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] FETCH  = 2'd1;
  localparam logic [1:0] SEND   = 2'd2;
  localparam logic [1:0] FINISH = 2'd3;
  localparam int M_DEFAULT = 5;
  localparam int REG_COUNT = 1 << M_DEFAULT;
  function automatic int regCount(input int m);
    return 1 << m;
  endfunction
endpackage

// File: rtl/regfile_dump_unit.sv
// regfile_dump_unit: walks the register file and streams {index, value} pairs over valid/ready
module regfile_dump_unit
  import regfile_dump_unit_pkg::*;
#(
  parameter int n = 32,
  parameter int m = 5
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         start,
  input  logic         abort,
  output logic [m-1:0] rf_read_addr,
  input  logic [n-1:0] rf_read_data,
  output logic         dump_valid,
  input  logic         dump_ready,
  output logic [n-1:0] dump_data,
  output logic [m-1:0] dump_index,
  output logic         dump_last,
  output logic         busy,
  output logic         done
);
  localparam int LAST = regCount(m) - 1;
  logic [1:0]   state;
  logic [m-1:0] idx;
  assign rf_read_addr = idx;
  assign busy = state != IDLE;
  // FSM, index counter and output holding register; abort outranks every handshake
  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= IDLE;
      idx        <= '0;
      dump_valid <= 1'b0;
      dump_data  <= '0;
      dump_index <= '0;
      dump_last  <= 1'b0;
      done       <= 1'b0;
    end else begin
      done <= 1'b0;
      if (abort && state != IDLE) begin
        state      <= IDLE;
        idx        <= '0;
        dump_valid <= 1'b0;
      end else begin
        case (state)
          IDLE: if (start && !abort) begin
            idx   <= '0;
            state <= FETCH;
          end
          FETCH: begin
            dump_data  <= rf_read_data;
            dump_index <= idx;
            dump_last  <= idx == LAST[m-1:0];
            dump_valid <= 1'b1;
            state      <= SEND;
          end
          SEND: if (dump_ready) begin
            dump_valid <= 1'b0;
            if (dump_last) begin
              state <= FINISH;
              done  <= 1'b1;
            end else begin
              idx   <= idx + 1'b1;
              state <= FETCH;
            end
          end
          FINISH: state <= IDLE;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_regfile_dump_unit.sv
// tb_regfile_dump_unit: directed checks of the register dump sequencer
module tb_regfile_dump_unit;
  logic        clock = 0, reset = 1, start = 0, abort = 0, dump_ready = 1;
  logic [4:0]  rf_read_addr, dump_index;
  logic [31:0] rf_read_data, dump_data;
  logic        dump_valid, dump_last, busy, done;
  logic [31:0] regs [32];
  logic [4:0]  gIdx [$];
  logic [31:0] gData [$];
  logic        gLast [$];
  int assertCount = 0, failCount = 0;
  int doneCount, doneCycle, stallSeen;
  int startAt = -1, wrCycle = -1, wrA = 0, wrB = 0;
  logic [31:0] wrAVal, wrBVal;
  assign rf_read_data = regs[rf_read_addr];
  regfile_dump_unit #(.n(32), .m(5)) dut (
    .clock(clock), .reset(reset), .start(start), .abort(abort),
    .rf_read_addr(rf_read_addr), .rf_read_data(rf_read_data),
    .dump_valid(dump_valid), .dump_ready(dump_ready), .dump_data(dump_data),
    .dump_index(dump_index), .dump_last(dump_last), .busy(busy), .done(done)
  );
  always #5 clock = ~clock;
  task automatic tick();
    @(posedge clock);
    #1;
  endtask
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    assertCount++;
    if (got !== exp) begin
      failCount++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  function automatic logic [31:0] initVal(input int i);
    return i == 0 ? 32'h0 : 32'hA5A50000 + 32'(i);
  endfunction
  // cycle c=1 is the first FETCH cycle after the start pulse
  task automatic runDump(input int stopAt, input int stallIdx, input int stallLen);
    int c;
    int stalls;
    bit ok;
    logic [31:0] hd;
    logic [4:0] hi;
    logic hl;
    c = 0; stalls = 0; ok = 0; hd = '0; hi = '0; hl = 0;
    gIdx.delete(); gData.delete(); gLast.delete();
    doneCount = 0; doneCycle = -1;
    dump_ready = 1; start = 1;
    tick();
    start = 0;
    while (c < 200) begin
      c++;
      if (c == stopAt) return;
      start = c == startAt;
      if (c == wrCycle) begin
        regs[wrA] = wrAVal;
        regs[wrB] = wrBVal;
      end
      dump_ready = !(dump_valid && dump_index == 5'(stallIdx) && stalls < stallLen);
      if (dump_valid && !dump_ready) begin
        if (stalls == 0) begin
          hd = dump_data; hi = dump_index; hl = dump_last;
        end else begin
          check("hold_data", dump_data, hd);
          check("hold_index", dump_index, hi);
          check("hold_last", dump_last, hl);
        end
        stalls++;
      end
      if (dump_valid && dump_ready) begin
        gIdx.push_back(dump_index);
        gData.push_back(dump_data);
        gLast.push_back(dump_last);
      end
      if (done) begin
        doneCount++;
        doneCycle = c;
      end
      if (!busy) begin
        ok = 1;
        break;
      end
      tick();
    end
    start = 0;
    dump_ready = 1;
    stallSeen = stalls;
    check("dump_completes", ok, 1);
  endtask
  task automatic checkFullDump(input string tag);
    check({tag, "_count"}, gIdx.size(), 32);
    for (int i = 0; i < gIdx.size() && i < 32; i++) begin
      check({tag, "_index"}, gIdx[i], i);
      check({tag, "_data"}, gData[i], initVal(i));
      check({tag, "_last"}, gLast[i], i == 31);
    end
  endtask
  task automatic checkIdleOutputs(input string tag);
    check({tag, "_valid"}, dump_valid, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_done"}, done, 0);
    check({tag, "_addr"}, rf_read_addr, 0);
  endtask
  initial begin
    for (int i = 0; i < 32; i++) regs[i] = initVal(i);
    tick(); tick();
    reset = 0;
    tick();
    checkIdleOutputs("reset");
    check("reset_data", dump_data, 0);
    check("reset_index", dump_index, 0);
    check("reset_last", dump_last, 0);
    start = 1; abort = 1;
    tick();
    start = 0; abort = 0;
    check("start_abort_idle_busy", busy, 0);
    runDump(-1, -1, 0);
    checkFullDump("t1");
    check("t1_done_count", doneCount, 1);
    check("t1_done_cycle", doneCycle, 65);
    runDump(-1, 7, 5);
    checkFullDump("t2");
    check("t2_stall_cycles", stallSeen, 5);
    check("t2_done_cycle", doneCycle, 70);
    runDump(26, -1, 0);
    check("t3_valid_before_abort", dump_valid, 1);
    check("t3_index_before_abort", dump_index, 12);
    check("t3_words_before_abort", gIdx.size(), 12);
    abort = 1; dump_ready = 1;
    tick();
    abort = 0;
    checkIdleOutputs("t3_abort");
    repeat (3) begin
      tick();
      check("t3_no_done", done, 0);
    end
    runDump(-1, -1, 0);
    checkFullDump("t3_restart");
    runDump(7, -1, 0);
    check("t4_fetch_busy", busy, 1);
    check("t4_fetch_addr", rf_read_addr, 3);
    reset = 1;
    tick();
    reset = 0;
    checkIdleOutputs("t4_reset");
    check("t4_reset_data", dump_data, 0);
    check("t4_reset_index", dump_index, 0);
    check("t4_reset_last", dump_last, 0);
    startAt = 10;
    runDump(-1, -1, 0);
    startAt = -1;
    checkFullDump("t4_busy_start");
    check("t4_done_count", doneCount, 1);
    check("t4_done_cycle", doneCycle, 65);
    wrCycle = 20; wrA = 20; wrAVal = 32'hDEADBEEF; wrB = 5; wrBVal = 32'h55555555;
    runDump(-1, -1, 0);
    wrCycle = -1;
    check("t5_count", gIdx.size(), 32);
    if (gIdx.size() == 32) begin
      check("t5_x20_new", gData[20], 32'hDEADBEEF);
      check("t5_x5_old", gData[5], initVal(5));
      check("t5_x19", gData[19], initVal(19));
      check("t5_x21", gData[21], initVal(21));
    end
    tick();
    check("t5_next_dump_x5", regs[5], 32'h55555555);
    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end
endmodule
